// File: rtl/ex_stage_pipelined.sv
// MIPS execute stage: forwarding muxes, ALU, branch-target adder, iterative
// shift-add multiplier with HI/LO, and the EX/MEM register with valid/stall/flush.
`timescale 1ns/1ps
module ex_stage_pipelined #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall_in,
    input  logic              flush,
    input  logic [CTL_W-1:0]  ctlwb_in,
    input  logic [CTL_W-1:0]  ctlm_in,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extend,
    input  logic [REG_W-1:0]  instr_2016,
    input  logic [REG_W-1:0]  instr_1511,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              alusrc,
    input  logic              regdst,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] exmem_fwd,
    input  logic [DATA_W-1:0] memwb_fwd,
    output logic              ex_stall,
    output logic              valid_out,
    output logic [CTL_W-1:0]  ctlwb_out,
    output logic [CTL_W-1:0]  ctlm_out,
    output logic [DATA_W-1:0] adder_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] rdata2_out,
    output logic [REG_W-1:0]  muxout_out,
    output logic              zero_out,
    output logic              ovf_out,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam int MSB = DATA_W - 1;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic                r_negate;

    logic                r_valid;
    logic [CTL_W-1:0]    r_ctlwb;
    logic [CTL_W-1:0]    r_ctlm;
    logic [DATA_W-1:0]   r_adder;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_rdata2;
    logic [REG_W-1:0]    r_muxout;
    logic                r_zero;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic [DATA_W-1:0]   w_opA;
    logic [DATA_W-1:0]   w_opB;
    logic [DATA_W-1:0]   w_aluB;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic                w_addOvf;
    logic                w_subOvf;
    logic [DATA_W-1:0]   w_result;
    logic                w_ovf;
    logic                w_isMult;
    logic                w_multSigned;
    logic [DATA_W-1:0]   w_adder;
    logic [REG_W-1:0]    w_dest;
    logic                w_negA;
    logic                w_negB;
    logic [DATA_W-1:0]   w_magA;
    logic [DATA_W-1:0]   w_magB;
    logic [2*DATA_W-1:0] w_accNext;
    logic [2*DATA_W-1:0] w_product;
    logic                w_issueStall;
    logic                w_mulBusy;

    always_comb begin
        case (fwd_a)
            2'b01:   w_opA = memwb_fwd;
            2'b10:   w_opA = exmem_fwd;
            default: w_opA = rdata1;
        endcase
        case (fwd_b)
            2'b01:   w_opB = memwb_fwd;
            2'b10:   w_opB = exmem_fwd;
            default: w_opB = rdata2;
        endcase
    end

    assign w_aluB   = alusrc ? s_extend : w_opB;
    assign w_adder  = npc + (s_extend << 2);
    assign w_dest   = regdst ? instr_1511 : instr_2016;
    assign w_sum    = w_opA + w_aluB;
    assign w_diff   = w_opA - w_aluB;
    assign w_addOvf = (w_opA[MSB] == w_aluB[MSB]) && (w_sum[MSB] != w_opA[MSB]);
    assign w_subOvf = (w_opA[MSB] != w_aluB[MSB]) && (w_diff[MSB] != w_opA[MSB]);

    // Overflow is reported only for the trapping R-type add/sub encodings.
    always_comb begin
        w_result     = '0;
        w_ovf        = 1'b0;
        w_isMult     = 1'b0;
        w_multSigned = 1'b0;
        case (alu_op)
            2'b00: w_result = w_sum;
            2'b01: w_result = w_diff;
            2'b11: w_result = w_opA | w_aluB;
            default: begin
                case (funct)
                    F_ADD: begin
                        w_result = w_sum;
                        w_ovf    = w_addOvf;
                    end
                    F_ADDU: w_result = w_sum;
                    F_SUB: begin
                        w_result = w_diff;
                        w_ovf    = w_subOvf;
                    end
                    F_SUBU: w_result = w_diff;
                    F_AND:  w_result = w_opA & w_aluB;
                    F_OR:   w_result = w_opA | w_aluB;
                    F_XOR:  w_result = w_opA ^ w_aluB;
                    F_NOR:  w_result = ~(w_opA | w_aluB);
                    F_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(w_opA) < $signed(w_aluB))};
                    F_SLTU: w_result = {{(DATA_W-1){1'b0}}, (w_opA < w_aluB)};
                    F_MFHI: w_result = r_hi;
                    F_MFLO: w_result = r_lo;
                    F_MULT: begin
                        w_isMult     = 1'b1;
                        w_multSigned = 1'b1;
                    end
                    F_MULTU: w_isMult = 1'b1;
                    default: w_result = '0;
                endcase
            end
        endcase
    end

    // Signed multiply runs on magnitudes; the product is negated at the end.
    assign w_negA    = w_multSigned & w_opA[MSB];
    assign w_negB    = w_multSigned & w_opB[MSB];
    assign w_magA    = w_negA ? (~w_opA + 1'b1) : w_opA;
    assign w_magB    = w_negB ? (~w_opB + 1'b1) : w_opB;
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : {(2*DATA_W){1'b0}});
    assign w_product = r_negate ? (~w_accNext + 1'b1) : w_accNext;

    assign w_issueStall = (r_state == S_IDLE) && in_valid && w_isMult;
    assign w_mulBusy    = (r_state == S_MUL) && (r_cnt != CNT_LAST);
    assign ex_stall     = rst_n && (stall_in || w_issueStall || w_mulBusy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_negate <= 1'b0;
            r_valid  <= 1'b0;
            r_ctlwb  <= '0;
            r_ctlm   <= '0;
            r_adder  <= '0;
            r_alu    <= '0;
            r_rdata2 <= '0;
            r_muxout <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (flush) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_ctlwb  <= '0;
            r_ctlm   <= '0;
            r_adder  <= '0;
            r_alu    <= '0;
            r_rdata2 <= '0;
            r_muxout <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (!stall_in) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && w_isMult) begin
                        r_state  <= S_MUL;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{DATA_W{1'b0}}, w_magA};
                        r_mplier <= w_magB;
                        r_negate <= w_negA ^ w_negB;
                        r_valid  <= 1'b0;
                        r_ctlwb  <= '0;
                        r_ctlm   <= '0;
                        r_adder  <= '0;
                        r_alu    <= '0;
                        r_rdata2 <= '0;
                        r_muxout <= '0;
                        r_zero   <= 1'b0;
                        r_ovf    <= 1'b0;
                    end else begin
                        r_valid  <= in_valid;
                        r_ctlwb  <= in_valid ? ctlwb_in : '0;
                        r_ctlm   <= in_valid ? ctlm_in : '0;
                        r_adder  <= w_adder;
                        r_alu    <= w_result;
                        r_rdata2 <= w_opB;
                        r_muxout <= w_dest;
                        r_zero   <= (w_result == '0);
                        r_ovf    <= w_ovf;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= S_IDLE;
                        r_hi     <= w_product[2*DATA_W-1:DATA_W];
                        r_lo     <= w_product[DATA_W-1:0];
                        r_valid  <= 1'b1;
                        r_ctlwb  <= ctlwb_in;
                        r_ctlm   <= ctlm_in;
                        r_adder  <= w_adder;
                        r_alu    <= w_product[DATA_W-1:0];
                        r_rdata2 <= w_opB;
                        r_muxout <= w_dest;
                        r_zero   <= (w_product[DATA_W-1:0] == '0);
                        r_ovf    <= 1'b0;
                    end else begin
                        r_valid  <= 1'b0;
                        r_ctlwb  <= '0;
                        r_ctlm   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid_out      = r_valid;
    assign ctlwb_out      = r_ctlwb;
    assign ctlm_out       = r_ctlm;
    assign adder_out      = r_adder;
    assign alu_result_out = r_alu;
    assign rdata2_out     = r_rdata2;
    assign muxout_out     = r_muxout;
    assign zero_out       = r_zero;
    assign ovf_out        = r_ovf;
    assign hi_out         = r_hi;
    assign lo_out         = r_lo;

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// Scoreboard bench for ex_stage_pipelined: a behavioural model predicts every
// EX/MEM result; a monitor pops and compares whenever a new valid result appears.
`timescale 1ns/1ps
module tb_ex_stage_pipelined;

    typedef struct packed {
        logic [1:0]  aluOp;
        logic [5:0]  funct;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic        aluSrc;
        logic        regDst;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [31:0] npcV;
        logic [31:0] exmemV;
        logic [31:0] memwbV;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  cwb;
        logic [1:0]  cm;
    } instr_t;

    typedef struct packed {
        logic [1:0]  cwb;
        logic [1:0]  cm;
        logic [31:0] adder;
        logic [31:0] res;
        logic [31:0] rdata2;
        logic [4:0]  mux;
        logic        zero;
        logic        ovf;
        logic        checkOvf;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    localparam longint MAX_S = 64'sh7FFFFFFF;
    localparam longint MIN_S = -64'sh80000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        stall_in;
    logic        flush;
    logic [1:0]  ctlwb_in;
    logic [1:0]  ctlm_in;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] s_extend;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alusrc;
    logic        regdst;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] exmem_fwd;
    logic [31:0] memwb_fwd;
    logic        ex_stall;
    logic        valid_out;
    logic [1:0]  ctlwb_out;
    logic [1:0]  ctlm_out;
    logic [31:0] adder_out;
    logic [31:0] alu_result_out;
    logic [31:0] rdata2_out;
    logic [4:0]  muxout_out;
    logic        zero_out;
    logic        ovf_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          total = 0;
    int          bad = 0;
    exp_t        sbq[$];
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    logic [5:0]  fTab[15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h3F};
    logic [31:0] bTab[4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};

    ex_stage_pipelined dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
        .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
        .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
        .alu_op(alu_op), .funct(funct), .alusrc(alusrc), .regdst(regdst),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_fwd(exmem_fwd), .memwb_fwd(memwb_fwd),
        .ex_stall(ex_stall), .valid_out(valid_out), .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out),
        .adder_out(adder_out), .alu_result_out(alu_result_out), .rdata2_out(rdata2_out),
        .muxout_out(muxout_out), .zero_out(zero_out), .ovf_out(ovf_out),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pickOperand(input logic [1:0] sel, input logic [31:0] reg_v,
                                                input logic [31:0] memwb_v, input logic [31:0] exmem_v);
        if (sel == 2'b01) return memwb_v;
        if (sel == 2'b10) return exmem_v;
        return reg_v;
    endfunction

    function automatic logic signedOvf(input longint s);
        return (s > MAX_S) || (s < MIN_S);
    endfunction

    // Reference model: what the MEM stage should see for one instruction.
    function automatic exp_t predict(input instr_t t, input logic [31:0] hi, input logic [31:0] lo);
        exp_t        e;
        logic [31:0] a, bReg, b, res;
        logic [63:0] prod;
        longint      p;
        a    = pickOperand(t.fwdA, t.rd1, t.memwbV, t.exmemV);
        bReg = pickOperand(t.fwdB, t.rd2, t.memwbV, t.exmemV);
        b    = t.aluSrc ? t.sext : bReg;
        e.hi = hi;
        e.lo = lo;
        e.ovf = 1'b0;
        e.checkOvf = (t.aluOp == 2'b10);
        res = '0;
        case (t.aluOp)
            2'b00: res = a + b;
            2'b01: res = a - b;
            2'b11: res = a | b;
            default: begin
                case (t.funct)
                    6'h20: begin
                        res = a + b;
                        e.ovf = signedOvf(longint'($signed(a)) + longint'($signed(b)));
                    end
                    6'h21: res = a + b;
                    6'h22: begin
                        res = a - b;
                        e.ovf = signedOvf(longint'($signed(a)) - longint'($signed(b)));
                    end
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h10: res = hi;
                    6'h12: res = lo;
                    6'h18: begin
                        p    = longint'($signed(a)) * longint'($signed(bReg));
                        prod = p;
                        e.hi = prod[63:32];
                        e.lo = prod[31:0];
                        res  = prod[31:0];
                    end
                    6'h19: begin
                        prod = {32'd0, a} * {32'd0, bReg};
                        e.hi = prod[63:32];
                        e.lo = prod[31:0];
                        res  = prod[31:0];
                    end
                    default: res = '0;
                endcase
            end
        endcase
        e.res    = res;
        e.zero   = (res == 32'd0);
        e.adder  = t.npcV + t.sext * 32'd4;
        e.rdata2 = bReg;
        e.mux    = t.regDst ? t.rd : t.rt;
        e.cwb    = t.cwb;
        e.cm     = t.cm;
        return e;
    endfunction

    function automatic logic isMult(input instr_t t);
        return (t.aluOp == 2'b10) && ((t.funct == 6'h18) || (t.funct == 6'h19));
    endfunction

    function automatic instr_t mkInstr(input logic [1:0] op, input logic [5:0] fn,
                                       input logic [31:0] a, input logic [31:0] b);
        instr_t t;
        t.aluOp = op;   t.funct = fn;   t.fwdA = 2'b00; t.fwdB = 2'b00;
        t.aluSrc = 1'b0; t.regDst = 1'b1;
        t.rd1 = a;      t.rd2 = b;
        t.sext = $urandom; t.npcV = $urandom; t.exmemV = $urandom; t.memwbV = $urandom;
        t.rt = 5'($urandom); t.rd = 5'd10;
        t.cwb = 2'($urandom); t.cm = 2'($urandom);
        return t;
    endfunction

    function automatic logic [31:0] randOp();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return 32'(0 - $urandom_range(1, 20));
            2:       return $urandom;
            default: return bTab[$urandom_range(0, 3)];
        endcase
    endfunction

    function automatic instr_t randInstr();
        instr_t t;
        int     sel;
        t = mkInstr(2'b10, fTab[$urandom_range(0, 14)], randOp(), randOp());
        sel = $urandom_range(0, 9);
        if (sel < 2) begin
            t.aluOp = 2'b00;
            t.aluSrc = 1'($urandom);
        end else if (sel == 2) begin
            t.aluOp = 2'b01;
        end else if (sel == 3) begin
            t.aluOp = 2'b11;
            t.aluSrc = 1'($urandom);
        end
        t.fwdA = 2'($urandom);
        t.fwdB = 2'($urandom);
        t.exmemV = randOp();
        t.memwbV = randOp();
        t.sext = randOp();
        t.regDst = 1'($urandom);
        t.rd = 5'($urandom);
        return t;
    endfunction

    task automatic driveInputs(input instr_t t);
        alu_op = t.aluOp;   funct = t.funct;   fwd_a = t.fwdA;   fwd_b = t.fwdB;
        alusrc = t.aluSrc;  regdst = t.regDst; rdata1 = t.rd1;   rdata2 = t.rd2;
        s_extend = t.sext;  npc = t.npcV;      exmem_fwd = t.exmemV; memwb_fwd = t.memwbV;
        instr_2016 = t.rt;  instr_1511 = t.rd; ctlwb_in = t.cwb; ctlm_in = t.cm;
    endtask

    // Holds the instruction in ID/EX until the stage accepts it; returns the stalled edge count.
    task automatic applyStimulus(input instr_t t, output int stalledEdges);
        logic st;
        exp_t e;
        driveInputs(t);
        in_valid = 1'b1;
        stalledEdges = 0;
        forever begin
            #1 st = ex_stall;
            if (!st) begin
                e = predict(t, modelHi, modelLo);
                modelHi = e.hi;
                modelLo = e.lo;
                sbq.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
            if (!st) break;
            stalledEdges++;
            if (stalledEdges > 200) begin
                checkOutput("stall_timeout", 64'(stalledEdges), 64'd0);
                break;
            end
        end
        #1 checkOutput("result_latency", 64'(sbq.size()), 64'd0);
        in_valid = 1'b0;
    endtask

    initial begin : monitor
        logic edgeStall;
        exp_t e;
        forever begin
            @(posedge clk);
            edgeStall = stall_in;
            @(negedge clk);
            if (rst_n && valid_out && !edgeStall) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_valid", 64'(valid_out), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("alu_result", 64'(alu_result_out), 64'(e.res));
                    checkOutput("controls", 64'({ctlwb_out, ctlm_out}), 64'({e.cwb, e.cm}));
                    checkOutput("adder", 64'(adder_out), 64'(e.adder));
                    checkOutput("rdata2", 64'(rdata2_out), 64'(e.rdata2));
                    checkOutput("dest_reg", 64'(muxout_out), 64'(e.mux));
                    checkOutput("zero", 64'(zero_out), 64'(e.zero));
                    if (e.checkOvf) checkOutput("ovf", 64'(ovf_out), 64'(e.ovf));
                    checkOutput("hi_lo", {hi_out, lo_out}, {e.hi, e.lo});
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        instr_t t;
        int     n;
        int     got;
        rst_n = 1'b0; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        driveInputs(mkInstr(2'b10, 6'h20, 32'd1, 32'd2));
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 64'({valid_out, ctlwb_out, ctlm_out, alu_result_out, ex_stall}), 64'd0);
        rst_n = 1'b1;

        // R-type sweep
        applyStimulus(mkInstr(2'b10, 6'h20, 32'd10, 32'd20), n);
        checkOutput("add_10_20", 64'(alu_result_out), 64'd30);
        checkOutput("rd_select", 64'(muxout_out), 64'd10);
        applyStimulus(mkInstr(2'b10, 6'h22, 32'd30, 32'd15), n);
        applyStimulus(mkInstr(2'b10, 6'h25, 32'd12, 32'd5), n);
        applyStimulus(mkInstr(2'b10, 6'h24, 32'd14, 32'd7), n);
        applyStimulus(mkInstr(2'b10, 6'h2A, 32'd8, 32'd12), n);
        checkOutput("slt_8_12", 64'(alu_result_out), 64'd1);

        // Immediate add and branch target, then rt select
        t = mkInstr(2'b00, 6'h00, 32'd100, 32'd5);
        t.aluSrc = 1'b1; t.sext = 32'd20; t.npcV = 32'd100;
        applyStimulus(t, n);
        checkOutput("imm_add", 64'(alu_result_out), 64'd120);
        checkOutput("branch_target", 64'(adder_out), 64'd180);
        t.regDst = 1'b0; t.rt = 5'd15;
        applyStimulus(t, n);
        checkOutput("rt_select", 64'(muxout_out), 64'd15);

        // Forwarding
        t = mkInstr(2'b10, 6'h20, 32'd999, 32'd555);
        t.fwdA = 2'b10; t.exmemV = 32'd7; t.fwdB = 2'b01; t.memwbV = 32'd3;
        applyStimulus(t, n);
        checkOutput("fwd_add", 64'(alu_result_out), 64'd10);
        checkOutput("fwd_store_data", 64'(rdata2_out), 64'd3);

        // Signed multiply -6 * 7 and a following mflo
        applyStimulus(mkInstr(2'b10, 6'h18, 32'hFFFFFFFA, 32'd7), n);
        checkOutput("mult_stall_edges", 64'(n), 64'd32);
        checkOutput("mult_hi", 64'(hi_out), 64'hFFFFFFFF);
        checkOutput("mult_lo", 64'(lo_out), 64'hFFFFFFD6);
        applyStimulus(mkInstr(2'b10, 6'h12, 32'd0, 32'd0), n);
        checkOutput("mflo_after_mult", 64'(alu_result_out), 64'hFFFFFFD6);

        // Flush during the fifth multiply step aborts it
        driveInputs(mkInstr(2'b10, 6'h19, 32'd123, 32'd456));
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("flush_valid", 64'(valid_out), 64'd0);
        checkOutput("flush_hi_lo", {hi_out, lo_out}, {modelHi, modelLo});
        checkOutput("flush_idle", 64'(ex_stall), 64'd0);
        applyStimulus(mkInstr(2'b10, 6'h21, 32'd4, 32'd5), n);
        checkOutput("after_flush_no_stall", 64'(n), 64'd0);

        // stall_in for three edges mid-multiply delays completion by three edges
        t = mkInstr(2'b10, 6'h18, randOp(), randOp());
        driveInputs(t);
        in_valid = 1'b1;
        sbq.push_back(predict(t, modelHi, modelLo));
        {modelHi, modelLo} = {predict(t, modelHi, modelLo).hi, predict(t, modelHi, modelLo).lo};
        got = -1;
        for (int k = 1; k <= 60; k++) begin
            stall_in = (k >= 5) && (k <= 7);
            @(posedge clk);
            @(negedge clk);
            if (valid_out) begin
                got = k;
                break;
            end
        end
        stall_in = 1'b0;
        in_valid = 1'b0;
        checkOutput("stalled_mult_edge", 64'(got), 64'd36);
        #1 checkOutput("stalled_mult_drain", 64'(sbq.size()), 64'd0);

        // Outputs freeze while stall_in is high
        applyStimulus(mkInstr(2'b10, 6'h20, 32'd10, 32'd20), n);
        t = mkInstr(2'b10, 6'h22, 32'd50, 32'd8);
        stall_in = 1'b1;
        driveInputs(t);
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("frozen_valid", 64'(valid_out), 64'd1);
            checkOutput("frozen_result", 64'(alu_result_out), 64'd30);
        end
        stall_in = 1'b0;
        applyStimulus(t, n);
        checkOutput("unfrozen_sub", 64'(alu_result_out), 64'd42);

        // Asynchronous reset mid-cycle with a multiply waiting in ID/EX
        driveInputs(mkInstr(2'b10, 6'h18, 32'd3, 32'd3));
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctl", 64'({valid_out, ctlwb_out, ctlm_out, muxout_out, zero_out, ovf_out, ex_stall}), 64'd0);
        checkOutput("async_reset_data", {alu_result_out, adder_out}, 64'd0);
        checkOutput("async_reset_hilo", {hi_out, lo_out}, 64'd0);
        checkOutput("async_reset_rdata2", 64'(rdata2_out), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelHi = '0;
        modelLo = '0;

        // Randomised traffic with occasional bubbles
        for (int i = 0; i < 150; i++) begin
            t = randInstr();
            if ($urandom_range(0, 4) == 0) begin
                driveInputs(t);
                in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                checkOutput("bubble", 64'({valid_out, ctlwb_out, ctlm_out}), 64'd0);
            end else begin
                applyStimulus(t, n);
                checkOutput(isMult(t) ? "rand_mult_stall" : "rand_no_stall", 64'(n), isMult(t) ? 64'd32 : 64'd0);
            end
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
